cdb_arbiter: RTL and testbench

Single-port common data bus arbiter and broadcast register. It is the consumer side of the FU completion handshake: it collects `fu_done` and `fu_cdb_data_t` from every functional unit, picks one winner per cycle with round-robin priority, returns `cdb_ack` to the winner, and drives the registered CDB broadcast that the reservation stations, ROB and register file snoop. It sits between the FU arrays and all CDB listeners.

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_arbiter_rr_pick.sv | 35 +++
 rtl/cdb_arbiter.sv | 72 +++++++
 tb/tb_cdb_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: FU completion payload, CDB source count and
// the bundled broadcast seen by listeners.
package cdb_arbiter_pkg;

  localparam int NUM_ALU_CMP_UNITS = 2;
  localparam int NUM_MUL_UNITS     = 1;
  localparam int NUM_MEM_UNITS     = 1;
  localparam int NUM_CDB_SRCS      = NUM_ALU_CMP_UNITS + NUM_MUL_UNITS + NUM_MEM_UNITS;
  localparam int CDB_SRC_W         = $clog2(NUM_CDB_SRCS);

  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [4:0]  rd;
    logic [31:0] rd_v;
  } fu_cdb_data_t;

  typedef struct packed {
    logic                 valid;
    logic [CDB_SRC_W-1:0] src;
    fu_cdb_data_t         data;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate requests so the pointer lands at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N     = 4,
  parameter int SRC_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic             found,
  output logic [N-1:0]     grant,
  output logic [SRC_W-1:0] idx
);

  localparam logic [SRC_W:0] N_W = (SRC_W + 1)'(N);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [SRC_W-1:0] enc;
  logic [SRC_W:0]   sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = SRC_W'(i);
    end
    sum = {1'b0, enc} + {1'b0, ptr};
    if (sum >= N_W) sum = sum - N_W;
    idx   = sum[SRC_W-1:0];
    found = |req;
    grant = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one FU completion per cycle in round-robin order and
// registers the winning payload as the bus broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_CDB_SRCS = cdb_arbiter_pkg::NUM_CDB_SRCS,
  parameter int SRC_W        = $clog2(NUM_CDB_SRCS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  branch_mispredict,
  input  logic [NUM_CDB_SRCS-1:0]               fu_done,
  input  fu_cdb_data_t [NUM_CDB_SRCS-1:0]       fu_data,
  output logic [NUM_CDB_SRCS-1:0]               cdb_ack,
  output logic                                  cdb_valid,
  output fu_cdb_data_t                          cdb_data,
  output logic [SRC_W-1:0]                      cdb_src
);

  logic                    found;
  logic [NUM_CDB_SRCS-1:0] grant_oh;
  logic [SRC_W-1:0]        g;
  logic                    grant_en;

  logic                    cdb_valid_d, cdb_valid_q;
  fu_cdb_data_t            cdb_data_d,  cdb_data_q;
  logic [SRC_W-1:0]        cdb_src_d,   cdb_src_q;
  logic [SRC_W-1:0]        rr_ptr_d,    rr_ptr_q;

  rr_pick #(
    .N     (NUM_CDB_SRCS),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .req   (fu_done),
    .ptr   (rr_ptr_q),
    .found (found),
    .grant (grant_oh),
    .idx   (g)
  );

  // Flush and reset only gate the grant; the data path stays purely registered.
  always_comb begin
    grant_en    = found && !rst && !branch_mispredict;
    cdb_ack     = grant_en ? grant_oh : '0;
    cdb_valid_d = grant_en;
    cdb_data_d  = grant_en ? fu_data[g] : cdb_data_q;
    cdb_src_d   = grant_en ? g : cdb_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_en) begin
      rr_ptr_d = (g == SRC_W'(NUM_CDB_SRCS - 1)) ? '0 : g + SRC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed steps push expected ack and broadcast
// entries stamped with the cycle they belong to; a negedge monitor pops and compares.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     branch_mispredict = 1'b0;
  logic [3:0]               fu_done = '0;
  fu_cdb_data_t [3:0]       fu_data;
  logic [3:0]               cdb_ack;
  logic                     cdb_valid;
  fu_cdb_data_t             cdb_data;
  logic [1:0]               cdb_src;

  cdb_arbiter #(.NUM_CDB_SRCS(4), .SRC_W(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .branch_mispredict (branch_mispredict),
    .fu_done           (fu_done),
    .fu_data           (fu_data),
    .cdb_ack           (cdb_ack),
    .cdb_valid         (cdb_valid),
    .cdb_data          (cdb_data),
    .cdb_src           (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    logic [3:0] ack;
  } ack_exp_t;

  typedef struct {
    int           stamp;
    logic         valid;
    logic [1:0]   src;
    fu_cdb_data_t data;
  } bc_exp_t;

  ack_exp_t ackq[$];
  bc_exp_t  bcq[$];
  int       cyc = 0;
  int       nvec = 0;
  int       nfail = 0;
  logic     hs_phase = 1'b0;
  int       p1_seen = 0;

  function automatic fu_cdb_data_t pay(input int i);
    fu_cdb_data_t p;
    p.rob_idx = 6'(i + 8);
    p.rd      = 5'(i + 1);
    p.rd_v    = 32'hA000_0000 + 32'(i) * 32'h111;
    return p;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry due this cycle; anything older than now was missed.
  always @(negedge clk) begin
    ack_exp_t ae;
    bc_exp_t  be;
    while (ackq.size() > 0 && ackq[0].stamp <= cyc) begin
      ae = ackq.pop_front();
      nvec++;
      if (ae.stamp != cyc) begin
        nfail++;
        $display("FAIL ack_late stamp=%0d now=%0d", ae.stamp, cyc);
      end else if (cdb_ack !== ae.ack) begin
        nfail++;
        $display("FAIL cdb_ack cyc=%0d got=%b want=%b", cyc, cdb_ack, ae.ack);
      end
    end
    while (bcq.size() > 0 && bcq[0].stamp <= cyc) begin
      be = bcq.pop_front();
      nvec++;
      if (be.stamp != cyc) begin
        nfail++;
        $display("FAIL bc_late stamp=%0d now=%0d", be.stamp, cyc);
      end else if (cdb_valid !== be.valid) begin
        nfail++;
        $display("FAIL cdb_valid cyc=%0d got=%b want=%b", cyc, cdb_valid, be.valid);
      end
      nvec++;
      if (be.stamp == cyc && cdb_src !== be.src) begin
        nfail++;
        $display("FAIL cdb_src cyc=%0d got=%0d want=%0d", cyc, cdb_src, be.src);
      end
      nvec++;
      if (be.stamp == cyc && cdb_data !== be.data) begin
        nfail++;
        $display("FAIL cdb_data cyc=%0d got=%h want=%h", cyc, cdb_data, be.data);
      end
    end
    if (hs_phase && cdb_valid === 1'b1 && cdb_data === pay(1)) p1_seen++;
  end

  task automatic step(input logic r, input logic b, input logic [3:0] d,
                      input logic [3:0] eack, input logic ev, input logic [1:0] esrc,
                      input fu_cdb_data_t edata);
    @(posedge clk);
    #1;
    rst               = r;
    branch_mispredict = b;
    fu_done           = d;
    ackq.push_back('{stamp: cyc, ack: eack});
    bcq.push_back('{stamp: cyc + 1, valid: ev, src: esrc, data: edata});
  endtask

  initial begin
    fu_cdb_data_t z;
    z = '0;
    for (int i = 0; i < 4; i++) fu_data[i] = pay(i);

    // Reset held two cycles with all sources requesting
    step(1, 0, 4'b1111, 4'b0000, 0, 2'd0, z);
    step(1, 0, 4'b1111, 4'b0000, 0, 2'd0, z);
    // Release: pointer 0 grants source 0, then fairness rotation 1,2,3,0,1
    step(0, 0, 4'b1111, 4'b0001, 1, 2'd0, pay(0));
    step(0, 0, 4'b1111, 4'b0010, 1, 2'd1, pay(1));
    step(0, 0, 4'b1111, 4'b0100, 1, 2'd2, pay(2));
    step(0, 0, 4'b1111, 4'b1000, 1, 2'd3, pay(3));
    step(0, 0, 4'b1111, 4'b0001, 1, 2'd0, pay(0));
    step(0, 0, 4'b1111, 4'b0010, 1, 2'd1, pay(1));
    // Idle: src/data hold, pointer stays 2
    step(0, 0, 4'b0000, 4'b0000, 0, 2'd1, pay(1));
    // Source 3 alone moves pointer to 0
    step(0, 0, 4'b1000, 4'b1000, 1, 2'd3, pay(3));
    // Skip to 2 from pointer 0, then idle holds src 2 with pointer 3
    step(0, 0, 4'b0100, 4'b0100, 1, 2'd2, pay(2));
    step(0, 0, 4'b0000, 4'b0000, 0, 2'd2, pay(2));
    // Wrap: pointer 3 with 1001 picks 3, then 0
    step(0, 0, 4'b1001, 4'b1000, 1, 2'd3, pay(3));
    step(0, 0, 4'b0001, 4'b0001, 1, 2'd0, pay(0));
    // Mispredict blocks grant and keeps pointer at 1; next cycle grants source 1
    step(0, 1, 4'b0011, 4'b0000, 0, 2'd0, pay(0));
    step(0, 0, 4'b0011, 4'b0010, 1, 2'd1, pay(1));
    step(0, 0, 4'b0001, 4'b0001, 1, 2'd0, pay(0));
    // Reset wins over mispredict and clears everything
    step(1, 1, 4'b1111, 4'b0000, 0, 2'd0, z);
    // Handshake: source 0 re-requests every cycle, source 1 served once
    hs_phase = 1'b1;
    step(0, 0, 4'b0011, 4'b0001, 1, 2'd0, pay(0));
    step(0, 0, 4'b0011, 4'b0010, 1, 2'd1, pay(1));
    step(0, 0, 4'b0001, 4'b0001, 1, 2'd0, pay(0));
    step(0, 0, 4'b0001, 4'b0001, 1, 2'd0, pay(0));
    step(0, 0, 4'b0000, 4'b0000, 0, 2'd0, pay(0));

    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (ackq.size() != 0 || bcq.size() != 0) begin
      nfail++;
      $display("FAIL drain ackq=%0d bcq=%0d want=0", ackq.size(), bcq.size());
    end
    nvec++;
    if (p1_seen != 1) begin
      nfail++;
      $display("FAIL src1_payload_count got=%0d want=1", p1_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
